// File: rtl/export_arbiter.sv
// rtl/export_arbiter.sv - round-robin sequencer sharing one LED data exporter between N_REQ solvers
// Optional EXPORT_TAG_EN: each grant first shows a requester-index tag word before the real word.
module export_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 28,
  parameter int DWELL      = 96000000,
  parameter int CNT_W      = 27,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      exp_en,
  output logic [DATA_W-1:0]         exp_data,
  output logic                      busy,
  output logic [2:0]                cur_idx
);

  typedef enum logic [2:0] {S_IDLE, S_SHOW, S_GAP, S_TAG, S_TAGGAP} state_t;

`ifdef EXPORT_TAG_EN
  localparam state_t GRANT_STATE = S_TAG;
`else
  localparam state_t GRANT_STATE = S_SHOW;
`endif

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_ptr;
  logic [2:0]          r_idx;
  logic [DATA_W-1:0]   r_data;
  logic [N_REQ-1:0]    r_ack;

  logic [2*N_REQ-1:0]  w_rot;
  logic                w_found;
  logic [2:0]          w_off;
  logic [3:0]          w_sum;
  logic [2:0]          w_gnt_idx;
  logic [2:0]          w_nxt_ptr;
  logic [DATA_W-1:0]   w_gnt_data;
  logic                w_dwell_end;
  logic                w_gap_end;
  logic                w_arb;
  logic                w_grant;

  // Rotate so the search always starts at bit 0, then map the offset back to an index.
  always_comb begin
    w_rot   = {req_valid, req_valid} >> r_ptr;
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = 3'(k);
      end
    end
    w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    w_gnt_idx  = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : w_sum[2:0];
    w_nxt_ptr  = (w_gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : w_gnt_idx + 3'd1;
    w_gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == 3'(i)) w_gnt_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_dwell_end = (r_cnt == CNT_W'(DWELL - 1));
  assign w_gap_end   = (r_cnt == CNT_W'(GAP_CYCLES - 1));
  assign w_arb       = (r_state == S_IDLE) || (r_state == S_GAP && w_gap_end);
  assign w_grant     = w_arb && w_found;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = GRANT_STATE;
      S_SHOW:   if (w_dwell_end) w_next = S_GAP;
      S_GAP:    if (w_gap_end) w_next = w_found ? GRANT_STATE : S_IDLE;
`ifdef EXPORT_TAG_EN
      S_TAG:    if (w_dwell_end) w_next = S_TAGGAP;
      S_TAGGAP: if (w_gap_end) w_next = S_SHOW;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      r_ack   <= w_grant ? (N_REQ'(1) << w_gnt_idx) : '0;
      if (w_grant) begin
        r_data <= w_gnt_data;
        r_idx  <= w_gnt_idx;
        r_ptr  <= w_nxt_ptr;
      end else if (w_next == S_IDLE) begin
        r_data <= '0;
        r_idx  <= '0;
      end
    end
  end

  assign req_ack = r_ack;
  assign busy    = (r_state != S_IDLE);
  assign cur_idx = r_idx;
`ifdef EXPORT_TAG_EN
  assign exp_en   = (r_state == S_SHOW) || (r_state == S_TAG);
  assign exp_data = (r_state == S_TAG) ? DATA_W'({20'hFFFFF, 5'b0, r_idx}) : r_data;
`else
  assign exp_en   = (r_state == S_SHOW);
  assign exp_data = r_data;
`endif

endmodule

// File: tb/tb_export_arbiter.sv
// tb/tb_export_arbiter.sv - directed bench for export_arbiter (DWELL=16, GAP_CYCLES=2, N_REQ=4)
module tb_export_arbiter;
  localparam int N = 4;
  localparam int W = 28;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic           exp_en;
  logic [W-1:0]   exp_data;
  logic           busy;
  logic [2:0]     cur_idx;

  int total = 0;
  int bad = 0;

  export_arbiter #(.N_REQ(N), .DATA_W(W), .DWELL(16), .CNT_W(5), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .exp_en(exp_en), .exp_data(exp_data), .busy(busy), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({exp_en, busy, req_ack, exp_data, cur_idx} !== '0) begin
      bad++;
      $display("FAIL reset_async en=%0b busy=%0b ack=%b data=%h idx=%0d want all zero", exp_en, busy, req_ack, exp_data, cur_idx);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({exp_en, busy, req_ack, exp_data, cur_idx} !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d en=%0b busy=%0b ack=%b data=%h want all zero", c, exp_en, busy, req_ack, exp_data);
      end
    end
  endtask

  task automatic test_single();
    int hi;
    int lo;
    req_data[2*W +: W] = 28'hABCDEF1;
    req_valid = 4'b0100;
    tick();
    total++;
    if (req_ack !== 4'b0100 || exp_en !== 1'b1 || exp_data !== 28'hABCDEF1 || cur_idx !== 3'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant ack=%b en=%0b data=%h idx=%0d want ack=0100 en=1 data=abcdef1 idx=2", req_ack, exp_en, exp_data, cur_idx);
    end
    req_valid = '0;
    hi = 0;
    while (exp_en === 1'b1 && exp_data === 28'hABCDEF1 && hi < 100) begin
      hi++;
      tick();
      if (hi == 1) begin
        total++;
        if (req_ack !== 4'b0000) begin
          bad++;
          $display("FAIL single_ack_pulse ack=%b want 0000", req_ack);
        end
      end
    end
    total++;
    if (hi != 16) begin
      bad++;
      $display("FAIL single_dwell got=%0d want=16", hi);
    end
    lo = 0;
    while (busy === 1'b1 && exp_en === 1'b0 && lo < 100) begin
      lo++;
      tick();
    end
    total++;
    if (lo != 2 || busy !== 1'b0 || exp_data !== '0 || cur_idx !== 3'd0) begin
      bad++;
      $display("FAIL single_gap_idle gap=%0d busy=%0b data=%h idx=%0d want gap=2 busy=0 data=0 idx=0", lo, busy, exp_data, cur_idx);
    end
  endtask

  task automatic test_all_four();
    int order[$];
    int cyc = 0;
    int started = 0;
    int idx;
    int want_order[4] = '{0, 1, 2, 3};
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 28'h1000000 + 28'(i * 17);
    req_valid = 4'b1111;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (started != 0) cyc++;
      if (req_ack !== '0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
        order.push_back(idx);
        total++;
        if (idx >= 0 && exp_data !== 28'h1000000 + 28'(idx * 17)) begin
          bad++;
          $display("FAIL all4_data idx=%0d got=%h want=%h", idx, exp_data, 28'h1000000 + 28'(idx * 17));
        end
        if (idx >= 0) req_valid[idx] = 1'b0;
        started = 1;
      end
      if (started != 0 && busy === 1'b0) break;
    end
    total++;
    if (order.size() != 4) begin
      bad++;
      $display("FAIL all4_count got=%0d want=4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (order[k] != want_order[k]) begin
          bad++;
          $display("FAIL all4_order pos=%0d got=%0d want=%0d", k, order[k], want_order[k]);
        end
      end
    end
    total++;
    if (cyc != 72) begin
      bad++;
      $display("FAIL all4_total_cycles got=%0d want=72", cyc);
    end
  endtask

  task automatic test_fairness();
    int order[$];
    int since = -1;
    int idx;
    int want_order[4] = '{0, 3, 0, 0};
    int n;
    req_data[0 +: W]   = 28'h0000AAA;
    req_data[3*W +: W] = 28'h0000333;
    req_valid = 4'b0001;
    for (n = 0; n < 400 && order.size() < 4; n++) begin
      tick();
      if (since >= 0) since++;
      if (since == 3) req_valid[3] = 1'b1;
      if (req_ack !== '0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
        order.push_back(idx);
        if (idx == 3) req_valid[3] = 1'b0;
        if (since < 0) since = 0;
      end
    end
    req_valid = '0;
    total++;
    if (order.size() != 4) begin
      bad++;
      $display("FAIL fair_count got=%0d want=4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (order[k] != want_order[k]) begin
          bad++;
          $display("FAIL fair_order pos=%0d got=%0d want=%0d", k, order[k], want_order[k]);
        end
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL fair_idle_timeout busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_show();
    int n = 0;
    req_data[1*W +: W] = 28'h1111111;
    req_data[2*W +: W] = 28'h2222222;
    req_data[3*W +: W] = 28'h3333333;
    req_valid = 4'b0100;
    tick();
    while (req_ack === '0 && n < 50) begin
      n++;
      tick();
    end
    total++;
    if (req_ack !== 4'b0100) begin
      bad++;
      $display("FAIL rst_pre_grant ack=%b want 0100", req_ack);
    end
    req_valid = 4'b1010;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (exp_en !== 1'b0 || busy !== 1'b0 || exp_data !== '0 || cur_idx !== 3'd0) begin
      bad++;
      $display("FAIL rst_mid_show en=%0b busy=%0b data=%h idx=%0d want all zero", exp_en, busy, exp_data, cur_idx);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (req_ack !== 4'b0010 || exp_data !== 28'h1111111 || cur_idx !== 3'd1 || exp_en !== 1'b1) begin
      bad++;
      $display("FAIL rst_regrant ack=%b data=%h idx=%0d en=%0b want ack=0010 data=1111111 idx=1 en=1", req_ack, exp_data, cur_idx, exp_en);
    end
    req_valid = '0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle_timeout busy=%0b want 0", busy);
    end
  endtask

`ifdef EXPORT_TAG_EN
  task automatic test_tag();
    int cnt;
    logic [W-1:0] phase_data[2] = '{28'hFFFFF02, 28'h0000123};
    req_data[2*W +: W] = 28'h0000123;
    req_valid = 4'b0100;
    tick();
    total++;
    if (req_ack !== 4'b0100) begin
      bad++;
      $display("FAIL tag_ack ack=%b want 0100", req_ack);
    end
    req_valid = '0;
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      while (exp_en === 1'b1 && exp_data === phase_data[p] && cnt < 100) begin
        cnt++;
        tick();
      end
      total++;
      if (cnt != 16) begin
        bad++;
        $display("FAIL tag_dwell phase=%0d got=%0d want=16 data=%h", p, cnt, phase_data[p]);
      end
      cnt = 0;
      while (exp_en === 1'b0 && busy === 1'b1 && cnt < 100) begin
        cnt++;
        tick();
      end
      total++;
      if (cnt != 2) begin
        bad++;
        $display("FAIL tag_gap phase=%0d got=%0d want=2", p, cnt);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL tag_idle busy=%0b want 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_reset_mid_show();
`ifdef EXPORT_TAG_EN
    test_tag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
